// File: rtl/write_buffer_if.sv
// Bus bundle between the data cache, the write buffer and the RAM controller.
// slave  : the write buffer's view (accepts pushes, issues RAM writes).
// master : the surrounding system's view (cache pushing, RAM acknowledging).
interface write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // cache -> buffer
    logic              buffer_write;
    logic [2:0]        buffer_length;
    logic [ADDR_W-1:0] buffer_addr;
    logic [DATA_W-1:0] buffer_data;
    // buffer -> cache
    logic              buffer_busy;
    logic              buffer_full;
    logic              overflow;
    // RAM controller -> buffer
    logic              ram_busy;
    logic              ram_done;
    // buffer -> RAM controller
    logic              ram_write;
    logic [2:0]        ram_length;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport slave (
        input  buffer_write, buffer_length, buffer_addr, buffer_data,
        input  ram_busy, ram_done,
        output buffer_busy, buffer_full, overflow,
        output ram_write, ram_length, ram_addr, ram_data
    );

    modport master (
        output buffer_write, buffer_length, buffer_addr, buffer_data,
        output ram_busy, ram_done,
        input  buffer_busy, buffer_full, overflow,
        input  ram_write, ram_length, ram_addr, ram_data
    );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer between the data cache and the RAM controller.
// Stores are queued in a DEPTH-entry circular FIFO and drained one at a time:
// IDLE issues the head entry as a one-cycle ram_write pulse, WAIT holds the
// request stable until ram_done, then the head is popped.
// Optional build macro WRITE_BUFFER_COALESCE_EN: a word store to the same
// (non-IO) word as the youngest, not-in-flight entry overwrites it in place.
// ADDR_W/DATA_W must match the widths of the connected write_buffer_if.
module write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clock,
    input  logic          reset,
    write_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]        len;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{len: 3'd0, addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              ram_write_q, ram_write_d;
    logic [2:0]        ram_length_q, ram_length_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];

    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              alloc_s;
    logic              coalesce_s;
    entry_t            new_entry_s;

`ifdef WRITE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0]  youngest_s;
    logic              head_claimed_s;
`endif

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    assign new_entry_s = '{len: bus.buffer_length, addr: bus.buffer_addr, data: bus.buffer_data};

    // Status and RAM request outputs, all taken from registers.
    assign bus.buffer_busy = !empty_s;
    assign bus.buffer_full = full_s;
    assign bus.overflow    = overflow_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_length  = ram_length_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;

`ifdef WRITE_BUFFER_COALESCE_EN
    assign youngest_s = tail_q - PTR_W'(1);
    // The head is claimed when it is in flight or is being issued at this edge
    // (in IDLE a non-empty FIFO issues exactly when ram_busy is low).
    assign head_claimed_s = (state_q == ST_WAIT) || !bus.ram_busy;
`endif

    // Next-state: drain FSM, push/coalesce/overflow handling, pointer and count update.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        ram_write_d  = 1'b0;
        ram_length_d = ram_length_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        mem_d        = mem_q;
        pop_s        = 1'b0;
        alloc_s      = 1'b0;

        // Drain side: issue the head, then wait for its acknowledge.
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !bus.ram_busy) begin
                    ram_write_d  = 1'b1;
                    ram_length_d = mem_q[head_q].len;
                    ram_addr_d   = mem_q[head_q].addr;
                    ram_data_d   = mem_q[head_q].data;
                    state_d      = ST_WAIT;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.ram_done) begin
                    pop_s   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef WRITE_BUFFER_COALESCE_EN
        coalesce_s = bus.buffer_write && !empty_s
                     && (bus.buffer_length == 3'd4)
                     && !bus.buffer_addr[17]
                     && (bus.buffer_addr[ADDR_W-1:2] == mem_q[youngest_s].addr[ADDR_W-1:2])
                     && !(head_claimed_s && (youngest_s == head_q));
`else
        coalesce_s = 1'b0;
`endif

        // Push side: fullness is judged on the registered count, so a same-cycle
        // pop never frees a slot for the push.
        if (bus.buffer_write) begin
            if (coalesce_s) begin
`ifdef WRITE_BUFFER_COALESCE_EN
                mem_d[youngest_s] = new_entry_s;
`else
                mem_d[tail_q] = mem_q[tail_q];
`endif
            end else if (full_s) begin
                overflow_d = 1'b1;
            end else begin
                mem_d[tail_q] = new_entry_s;
                tail_d        = tail_q + PTR_W'(1);
                alloc_s       = 1'b1;
            end
        end else begin
            alloc_s = 1'b0;
        end

        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        case ({alloc_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State, pointer, status and RAM request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            head_q       <= {PTR_W{1'b0}};
            tail_q       <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            overflow_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            ram_length_q <= 3'd0;
            ram_addr_q   <= {ADDR_W{1'b0}};
            ram_data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            ram_write_q  <= ram_write_d;
            ram_length_q <= ram_length_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
        end
    end

    // FIFO entry storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: ENTRY_ZERO};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer.
// A background RAM model logs every ram_write pulse and answers with ram_done
// after a programmable delay; all stimulus and checks run in one initial block.
module tb_write_buffer;

    logic clock;
    logic reset;

    write_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [2:0]  log_len  [$];

    bit resp_en    = 1'b1;
    int resp_delay = 3;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM model: log each request, optionally acknowledge it resp_delay cycles later.
    initial begin
        bus.ram_done = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (bus.ram_write === 1'b1) begin
                log_addr.push_back(bus.ram_addr);
                log_data.push_back(bus.ram_data);
                log_len.push_back(bus.ram_length);
                if (resp_en) begin
                    repeat (resp_delay) @(posedge clock);
                    #2 bus.ram_done = 1'b1;
                    @(posedge clock);
                    #2 bus.ram_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] len, input logic [31:0] addr, input logic [31:0] data);
        bus.buffer_write  = 1'b1;
        bus.buffer_length = len;
        bus.buffer_addr   = addr;
        bus.buffer_data   = data;
        tick(1);
        bus.buffer_write  = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int c = 0;
        while (log_addr.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check(tag, 64'(log_addr.size()), 64'(n));
    endtask

    task automatic check_write(input string tag, input int idx, input logic [2:0] len,
                               input logic [31:0] addr, input logic [31:0] data);
        if (idx < log_addr.size()) begin
            check({tag, "_len"},  64'(log_len[idx]),  64'(len));
            check({tag, "_addr"}, 64'(log_addr[idx]), 64'(addr));
            check({tag, "_data"}, 64'(log_data[idx]), 64'(data));
        end else begin
            check({tag, "_present"}, 64'(log_addr.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     64'(bus.buffer_busy), 64'(0));
        check({tag, "_full"},     64'(bus.buffer_full), 64'(0));
        check({tag, "_overflow"}, 64'(bus.overflow),    64'(0));
        check({tag, "_ram_write"},64'(bus.ram_write),   64'(0));
        check({tag, "_ram_len"},  64'(bus.ram_length),  64'(0));
        check({tag, "_ram_addr"}, 64'(bus.ram_addr),    64'(0));
        check({tag, "_ram_data"}, 64'(bus.ram_data),    64'(0));
    endtask

    initial begin
        int base;
        int n_exp;

        reset             = 1'b0;
        bus.buffer_write  = 1'b0;
        bus.buffer_length = 3'd0;
        bus.buffer_addr   = 32'd0;
        bus.buffer_data   = 32'd0;
        bus.ram_busy      = 1'b0;

        // ---- reset state ----
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b1;
        tick(2);
        check_idle_outputs("post_reset");

        // ---- single store: issue latency and busy fall on the done edge ----
        resp_en    = 1'b1;
        resp_delay = 3;
        base       = log_addr.size();
        push(3'd4, 32'h0000_1000, 32'hDEAD_BEEF);          // edge E0
        check("single_busy_after_push", 64'(bus.buffer_busy), 64'(1));
        check("single_no_write_yet",    64'(bus.ram_write),   64'(0));
        tick(1);                                            // edge E1
        check("single_write_pulse", 64'(bus.ram_write),  64'(1));
        check("single_len",         64'(bus.ram_length), 64'(4));
        check("single_addr",        64'(bus.ram_addr),   64'(32'h0000_1000));
        check("single_data",        64'(bus.ram_data),   64'(32'hDEAD_BEEF));
        tick(1);                                            // E2
        check("single_pulse_one_cycle", 64'(bus.ram_write), 64'(0));
        check("single_addr_held",       64'(bus.ram_addr),  64'(32'h0000_1000));
        tick(2);                                            // E4: ram_done high after this edge
        check("single_busy_before_done", 64'(bus.buffer_busy), 64'(1));
        tick(1);                                            // E5: pop
        check("single_busy_falls", 64'(bus.buffer_busy), 64'(0));
        tick(5);
        check("single_one_write", 64'(log_addr.size()), 64'(base + 1));
        check_write("single_log", base, 3'd4, 32'h0000_1000, 32'hDEAD_BEEF);

        // ---- ordering and pointer wrap ----
        resp_delay = 1;
        base       = log_addr.size();
        for (int i = 0; i < 6; i++) begin
            push(3'd1, 32'h10 + 32'(i), 32'h01 + 32'(i));
            tick(1);
        end
        wait_writes("order_count", base + 6, 200);
        for (int i = 0; i < 6; i++) begin
            check_write("order", base + i, 3'd1, 32'h10 + 32'(i), 32'h01 + 32'(i));
        end
        tick(5);
        check("order_exact_count", 64'(log_addr.size()), 64'(base + 6));
        check("order_drained",     64'(bus.buffer_busy), 64'(0));
        check("order_no_overflow", 64'(bus.overflow),    64'(0));

        // ---- overflow with RAM stalled ----
        base         = log_addr.size();
        bus.ram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(3'd4, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        check("ovf_full_after_4",   64'(bus.buffer_full), 64'(1));
        check("ovf_clear_after_4",  64'(bus.overflow),    64'(0));
        push(3'd4, 32'h110, 32'hA4);
        check("ovf_set_after_5",    64'(bus.overflow),    64'(1));
        check("ovf_no_write_stall", 64'(log_addr.size()), 64'(base));
        bus.ram_busy = 1'b0;
        wait_writes("ovf_count", base + 4, 200);
        tick(20);
        check("ovf_exact_count", 64'(log_addr.size()), 64'(base + 4));
        for (int i = 0; i < 4; i++) begin
            check_write("ovf", base + i, 3'd4, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        check("ovf_sticky", 64'(bus.overflow),    64'(1));
        check("ovf_full_clears", 64'(bus.buffer_full), 64'(0));

        // ---- back-pressure: registered issue after ram_busy falls ----
        base         = log_addr.size();
        bus.ram_busy = 1'b1;
        push(3'd2, 32'h0002_0300, 32'h0000_BEEF);   // addr[17]=1: IO space
        tick(10);
        check("bp_no_write_while_busy", 64'(log_addr.size()), 64'(base));
        check("bp_busy_pending",        64'(bus.buffer_busy), 64'(1));
        bus.ram_busy = 1'b0;
        check("bp_not_same_cycle", 64'(bus.ram_write), 64'(0));
        tick(1);
        check("bp_write_next",  64'(bus.ram_write), 64'(1));
        check("bp_addr",        64'(bus.ram_addr),  64'(32'h0002_0300));
        check("bp_len",         64'(bus.ram_length),64'(2));
        check("bp_data",        64'(bus.ram_data),  64'(32'h0000_BEEF));
        wait_writes("bp_count", base + 1, 50);
        tick(6);
        check("bp_drained", 64'(bus.buffer_busy), 64'(0));

        // ---- reset while a write is in flight ----
        resp_en      = 1'b0;
        bus.ram_busy = 1'b1;
        push(3'd4, 32'h400, 32'h1);
        push(3'd4, 32'h404, 32'h2);
        push(3'd4, 32'h408, 32'h3);
        bus.ram_busy = 1'b0;
        tick(2);
        check("rst_in_flight_addr", 64'(bus.ram_addr), 64'(32'h400));
        reset = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        tick(2);
        reset = 1'b1;
        base  = log_addr.size();
        tick(10);
        check("rst_no_write_after", 64'(log_addr.size()), 64'(base));
        check("rst_not_busy",       64'(bus.buffer_busy), 64'(0));
        resp_en = 1'b1;

        // ---- coalescing (or strict allocation when the feature is off) ----
        base         = log_addr.size();
        bus.ram_busy = 1'b1;
        push(3'd4, 32'h500,  32'h55);
        push(3'd4, 32'h2000, 32'h1111_1111);
        push(3'd4, 32'h2000, 32'h2222_2222);
        push(3'd4, 32'h3000, 32'h33);
`ifdef WRITE_BUFFER_COALESCE_EN
        check("coal_full", 64'(bus.buffer_full), 64'(0));
        n_exp = 3;
`else
        check("coal_full", 64'(bus.buffer_full), 64'(1));
        n_exp = 4;
`endif
        check("coal_no_overflow", 64'(bus.overflow), 64'(0));
        bus.ram_busy = 1'b0;
        wait_writes("coal_count", base + n_exp, 300);
        tick(20);
        check("coal_exact_count", 64'(log_addr.size()), 64'(base + n_exp));
        check_write("coal_w0", base, 3'd4, 32'h500, 32'h55);
`ifdef WRITE_BUFFER_COALESCE_EN
        check_write("coal_w1", base + 1, 3'd4, 32'h2000, 32'h2222_2222);
        check_write("coal_w2", base + 2, 3'd4, 32'h3000, 32'h33);
`else
        check_write("coal_w1", base + 1, 3'd4, 32'h2000, 32'h1111_1111);
        check_write("coal_w2", base + 2, 3'd4, 32'h2000, 32'h2222_2222);
        check_write("coal_w3", base + 3, 3'd4, 32'h3000, 32'h33);
`endif
        check("coal_drained", 64'(bus.buffer_busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write buffer directly downstream of the data cache.
- Accepts byte/half/word stores and dirty-line flushes from the data cache's buffer_* interface, queues them in a small FIFO and drains them one at a time to the RAM controller's write port.
- Lets the cache retire stores without waiting for memory.
- buffer_busy tells the cache that posted writes are still pending, so it orders reads and stores against them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, address width (matches MemAddrBus).
- DATA_W, 32, data width (matches MemDataBus).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- buffer_write  in  1  push strobe from the data cache (one-cycle pulse per store).
- buffer_length  in  3  one-hot size: 1 = byte, 2 = half, 4 = word.
- buffer_addr  in  ADDR_W  byte address of the store.
- buffer_data  in  DATA_W  store data, right-aligned for byte/half.
- buffer_busy  out  1  at least one entry not yet acknowledged by RAM.
- buffer_full  out  1  count == DEPTH.
- overflow  out  1  sticky error: a push arrived while full.
- ram_busy  in  1  RAM controller cannot accept a request this cycle.
- ram_done  in  1  one-cycle pulse: the in-flight write is complete.
- ram_write  out  1  one-cycle write request pulse.
- ram_length  out  3  size of the issued write.
- ram_addr  out  ADDR_W  address of the issued write.
- ram_data  out  DATA_W  data of the issued write.

Behaviour:
- Reset (reset low, asynchronous):
  - head, tail, count = 0; state = IDLE; overflow = 0.
  - ram_write = 0; ram_length, ram_addr, ram_data = 0.
  - An in-flight write is abandoned. The RAM controller is reset in the same domain.
- Storage: circular FIFO; head/tail are log2(DEPTH)-bit pointers that wrap modulo DEPTH. count is separate and log2(DEPTH)+1 bits wide.
- buffer_busy = (count != 0). buffer_full = (count == DEPTH). Both are decoded from registers, never from inputs.
- Push:
  - On a rising edge with buffer_write=1 and buffer_full=0, write {length, addr, data} at tail and advance tail.
  - On a rising edge with buffer_write=1 and buffer_full=1, drop the entry and set overflow to 1 (cleared only by reset).
  - A pop in the same cycle does not make room for a push while full.
- State machine, 2 states:
  - IDLE: at an edge where count != 0 and ram_busy=0:
    - Register the head entry onto ram_length/ram_addr/ram_data.
    - Drive ram_write=1 for exactly one cycle.
    - Go to WAIT. The entry stays in the FIFO.
  - WAIT: ram_write=0; ram_addr/length/data are held stable. On ram_done=1, pop head (head+1, count-1) and go to IDLE.
  - ram_done while in IDLE is ignored.
- Simultaneous push and pop (not full): count is unchanged, both pointers advance.
- Issue order is strict FIFO. Entries with addr[17]=1 (IO space) are issued exactly as received.
- Latency, empty buffer with ram_busy=0:
  - push at edge E0;
  - ram_write high in the cycle after edge E1;
  - the pop on the ram_done edge lowers buffer_busy at that edge if nothing else is queued.
- Back-to-back drain: at most one write per IDLE→WAIT→IDLE round trip. The next issue is no earlier than the edge after the pop.

Optional Feature:
- WRITE_BUFFER_COALESCE_EN
- Defined: a push that meets all of the following overwrites the youngest entry in place instead of allocating a new slot:
  - buffer_length=4 (word);
  - addr[17]=0;
  - addr[ADDR_W-1:2] equals the word address of the youngest entry;
  - the youngest entry is not the in-flight head.
  - A coalesced push does not change count and is accepted even when full.
- Undefined: every push allocates a slot; the full/overflow rules above apply unchanged.

Test Plan:
- Single store: push word addr 0x00001000, data 0xDEADBEEF, ram_busy=0, ram_done 3 cycles after ram_write → ram_write pulses once with length 4/0x1000/0xDEADBEEF; buffer_busy falls on the done edge.
- Ordering and wrap: push 6 byte stores to 0x10..0x15 with data 0x01..0x06 while draining → RAM sees exactly 0x10..0x15 in order; pointers wrap past DEPTH-1 with no loss.
- Overflow: hold ram_busy=1 and push 5 words → buffer_full=1 after the 4th push; the 5th push sets overflow=1; release ram_busy → only 4 writes are issued.
- Back-pressure: ram_busy=1 for 10 cycles with 1 entry → no ram_write; the first ram_write comes the cycle after ram_busy falls (registered issue).
- Reset mid-operation: assert reset in WAIT with 3 entries → all outputs 0 immediately; after release buffer_busy=0 and ram_write never fires.
- Coalesce (macro defined): hold ram_busy=1 with one queued entry, push word 0x2000/0x11111111 then word 0x2000/0x22222222 → count goes 1→2→2; after release only 0x22222222 is written to 0x2000. Without the macro: both writes are issued, in order.
